// File: rtl/fir_chan_sched.sv
// Shares one NUM_CH-way interleaved FIR between NUM_CH channels: collects one sample per
// channel, issues the frame ch0..chN-1 to the FIR sink and routes returned results back in order.
module fir_chan_sched #(
    parameter int NUM_CH = 2,
    parameter int DW     = 24,
    parameter int GAP    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_data,
    output logic [DW-1:0]        fir_sink_data,
    output logic                 fir_sink_valid,
    output logic [1:0]           fir_sink_error,
    input  logic [DW-1:0]        fir_source_data,
    input  logic                 fir_source_valid,
    input  logic [1:0]           fir_source_error,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]    out_valid,
    output logic                 overrun,
    output logic                 fir_err,
    input  logic                 clear
);

    localparam int CW = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         icnt_q, icnt_d;
    logic [CW-1:0]         ocnt_q, ocnt_d;
    logic [3:0]            gcnt_q, gcnt_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [DW-1:0]         hold_q [NUM_CH];
    logic [DW-1:0]         hold_d [NUM_CH];
    logic [DW-1:0]         sink_data_q, sink_data_d;
    logic [NUM_CH*DW-1:0]  out_data_q, out_data_d;
    logic [NUM_CH-1:0]     out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  fir_err_q, fir_err_d;
    logic [NUM_CH-1:0]     issue_mask;
    logic                  ovr_set;
    logic                  err_set;

    always_comb begin
        state_d     = state_q;
        icnt_d      = icnt_q;
        ocnt_d      = ocnt_q;
        gcnt_d      = gcnt_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        sink_data_d = sink_data_q;
        out_data_d  = out_data_q;
        out_valid_d = '0;
        issue_mask  = '0;
        ovr_set     = 1'b0;
        err_set     = 1'b0;

        if (state_q == ST_ISSUE) begin
            issue_mask[icnt_q] = 1'b1;
        end

        // A strobe in the issue cycle of its own channel starts the next frame, not an overrun
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i]) begin
                hold_d[i] = in_data[i*DW +: DW];
                pend_d[i] = 1'b1;
                if (pend_q[i] && !issue_mask[i]) begin
                    ovr_set = 1'b1;
                end
            end else if (issue_mask[i]) begin
                pend_d[i] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (&pend_q) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sink_data_d = hold_q[icnt_q];
                if (icnt_q == LAST_CH) begin
                    icnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    icnt_d = icnt_q + CW'(1);
                    if (GAP > 0) begin
                        gcnt_d  = 4'd0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fir_source_valid) begin
            out_data_d[ocnt_q*DW +: DW] = fir_source_data;
            out_valid_d[ocnt_q]         = 1'b1;
            ocnt_d                      = (ocnt_q == LAST_CH) ? '0 : ocnt_q + CW'(1);
            err_set                     = |fir_source_error;
        end

        overrun_d = ovr_set | (overrun_q & ~clear);
        fir_err_d = err_set | (fir_err_q & ~clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            icnt_q      <= '0;
            ocnt_q      <= '0;
            gcnt_q      <= '0;
            pend_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
            sink_data_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            overrun_q   <= 1'b0;
            fir_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            icnt_q      <= icnt_d;
            ocnt_q      <= ocnt_d;
            gcnt_q      <= gcnt_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            sink_data_q <= sink_data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            fir_err_q   <= fir_err_d;
        end
    end

    // The sink bus shows the live beat and otherwise keeps the last issued sample
    assign fir_sink_valid = (state_q == ST_ISSUE);
    assign fir_sink_data  = fir_sink_valid ? hold_q[icnt_q] : sink_data_q;
    assign fir_sink_error = 2'd0;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign overrun        = overrun_q;
    assign fir_err        = fir_err_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Scoreboard bench for fir_chan_sched: stimulus pushes expected sink beats and return
// updates into queues, negedge monitors pop and compare them against the DUT.
module tb_fir_chan_sched;

    localparam int NUM_CH = 2;
    localparam int DW     = 24;
    localparam int GAP    = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH*DW-1:0] in_data;
    logic [DW-1:0]        fir_sink_data;
    logic                 fir_sink_valid;
    logic [1:0]           fir_sink_error;
    logic [DW-1:0]        fir_source_data;
    logic                 fir_source_valid;
    logic [1:0]           fir_source_error;
    logic [NUM_CH*DW-1:0] out_data;
    logic [NUM_CH-1:0]    out_valid;
    logic                 overrun;
    logic                 fir_err;
    logic                 clear;

    fir_chan_sched #(.NUM_CH(NUM_CH), .DW(DW), .GAP(GAP)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .fir_sink_data    (fir_sink_data),
        .fir_sink_valid   (fir_sink_valid),
        .fir_sink_error   (fir_sink_error),
        .fir_source_data  (fir_source_data),
        .fir_source_valid (fir_source_valid),
        .fir_source_error (fir_source_error),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .overrun          (overrun),
        .fir_err          (fir_err),
        .clear            (clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } beat_t;

    typedef struct {
        logic [NUM_CH-1:0]    vld;
        logic [NUM_CH*DW-1:0] data;
        int                   at;
    } ret_t;

    beat_t                sink_exp[$];
    ret_t                 ret_exp[$];
    logic [DW-1:0]        last_val [NUM_CH];
    logic [NUM_CH*DW-1:0] out_model;
    int                   ocnt_model;
    int                   drive_cyc;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of input strobes; drive_cyc records the cycle the strobe was presented
    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DW-1:0] d);
        drive_cyc = cyc;
        in_valid  = v;
        in_data   = d;
        for (int c = 0; c < NUM_CH; c++) begin
            if (v[c]) last_val[c] = d[c*DW +: DW];
        end
        tick();
        in_valid = '0;
    endtask

    task automatic strobeOne(input int ch, input logic [DW-1:0] val);
        logic [NUM_CH-1:0]    v;
        logic [NUM_CH*DW-1:0] d;
        v = '0;
        d = '0;
        v[ch] = 1'b1;
        d[ch*DW +: DW] = val;
        applyStimulus(v, d);
    endtask

    // The frame completes at drive_cyc; channel k must appear (GAP+1)*k cycles after the first beat
    task automatic expectFrame(input int m);
        beat_t b;
        for (int k = 0; k < NUM_CH; k++) begin
            b.data = last_val[k];
            b.at   = m + 2 + k * (GAP + 1);
            sink_exp.push_back(b);
        end
    endtask

    task automatic sendReturn(input logic [DW-1:0] data, input logic [1:0] err);
        ret_t r;
        out_model[ocnt_model*DW +: DW] = data;
        r.vld = '0;
        r.vld[ocnt_model] = 1'b1;
        r.data = out_model;
        r.at   = cyc + 1;
        ret_exp.push_back(r);
        ocnt_model = (ocnt_model + 1) % NUM_CH;
        fir_source_valid = 1'b1;
        fir_source_data  = data;
        fir_source_error = err;
        tick();
        fir_source_valid = 1'b0;
        fir_source_error = 2'd0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sink_exp.size() != 0 || ret_exp.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checkOutput("drain timeout", 64'(sink_exp.size() + ret_exp.size()), 64'd0);
            sink_exp.delete();
            ret_exp.delete();
        end
        tick();
        tick();
    endtask

    // Monitor: every sink beat and every out_valid pulse must match the head of its queue
    always @(negedge clk) begin
        beat_t b;
        ret_t  r;
        if (!reset && fir_sink_valid) begin
            checkOutput("sink error field", 64'(fir_sink_error), 64'd0);
            if (sink_exp.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected sink beat: got %0h, expected none (cycle %0d)", fir_sink_data, cyc);
            end else begin
                b = sink_exp.pop_front();
                checkOutput("sink data", 64'(fir_sink_data), 64'(b.data));
                checkOutput("sink beat cycle", 64'(cyc), 64'(b.at));
            end
        end
        if (!reset && out_valid != '0) begin
            if (ret_exp.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected out_valid: got %0h, expected none (cycle %0d)", out_valid, cyc);
            end else begin
                r = ret_exp.pop_front();
                checkOutput("out_valid", 64'(out_valid), 64'(r.vld));
                checkOutput("out_data", 64'(out_data), 64'(r.data));
                checkOutput("out_valid cycle", 64'(cyc), 64'(r.at));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0]    v;
        logic [NUM_CH*DW-1:0] d;
        int                   reps [NUM_CH];
        int                   f;
        int                   m;
        logic                 exp_ovr;
        logic                 busy;
        logic [DW-1:0]        ra, rb, rc;

        reset            = 1'b1;
        in_valid         = '0;
        in_data          = '0;
        fir_source_valid = 1'b0;
        fir_source_data  = '0;
        fir_source_error = 2'd0;
        clear            = 1'b0;
        out_model        = '0;
        ocnt_model       = 0;
        for (int c = 0; c < NUM_CH; c++) last_val[c] = '0;
        #1;
        checkOutput("reset sink_valid", 64'(fir_sink_valid), 64'd0);
        checkOutput("reset sink_data", 64'(fir_sink_data), 64'd0);
        checkOutput("reset out_data", 64'(out_data), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset flags", 64'({overrun, fir_err}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] basic two-channel frame");
        applyStimulus(2'b11, {24'h000100, 24'hFFFF00});
        expectFrame(drive_cyc);
        waitDrain();
        checkOutput("basic overrun", 64'(overrun), 64'd0);

        $display("[TB] overwrite before issue");
        strobeOne(0, 24'h000011);
        tick();
        strobeOne(0, 24'h000022);
        tick();
        strobeOne(1, 24'h123456);
        expectFrame(drive_cyc);
        waitDrain();
        checkOutput("overwrite overrun", 64'(overrun), 64'd1);
        pulseClear();
        checkOutput("overrun cleared", 64'(overrun), 64'd0);

        $display("[TB] strobe during own issue cycle");
        applyStimulus(2'b11, {24'hA1A1A1, 24'hA0A0A0});
        expectFrame(drive_cyc);
        tick();
        strobeOne(0, 24'hB0B0B0);
        waitDrain();
        checkOutput("issue-cycle strobe overrun", 64'(overrun), 64'd0);
        strobeOne(1, 24'hB1B1B1);
        expectFrame(drive_cyc);
        waitDrain();
        checkOutput("follow-up frame overrun", 64'(overrun), 64'd0);

        $display("[TB] randomized frames");
        for (int it = 0; it < 20; it++) begin
            f       = $urandom_range(0, NUM_CH - 1);
            exp_ovr = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                reps[c] = (c == f) ? 0 : $urandom_range(1, 3);
                if (reps[c] > 1) exp_ovr = 1'b1;
            end
            busy = 1'b1;
            while (busy) begin
                v = '0;
                d = '0;
                busy = 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (reps[c] > 0 && $urandom_range(0, 1) == 1) begin
                        v[c] = 1'b1;
                        d[c*DW +: DW] = DW'($urandom);
                        reps[c]--;
                    end
                    if (reps[c] > 0) busy = 1'b1;
                end
                if (v != '0) applyStimulus(v, d);
                else tick();
            end
            strobeOne(f, DW'($urandom));
            expectFrame(drive_cyc);
            waitDrain();
            checkOutput("random overrun", 64'(overrun), 64'(exp_ovr));
            pulseClear();
        end

        $display("[TB] return path wrap");
        ra = 24'h0AAAAA;
        rb = 24'h0BBBBB;
        rc = 24'h0CCCCC;
        sendReturn(ra, 2'd0);
        sendReturn(rb, 2'd0);
        sendReturn(rc, 2'd0);
        waitDrain();
        checkOutput("wrap out_data", 64'(out_data), 64'({rb, rc}));
        checkOutput("no fir_err", 64'(fir_err), 64'd0);
        for (int it = 0; it < 12; it++) begin
            sendReturn(DW'($urandom), 2'd0);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        waitDrain();

        $display("[TB] FIR error reporting");
        sendReturn(24'h0E0E0E, 2'b01);
        waitDrain();
        checkOutput("fir_err set", 64'(fir_err), 64'd1);
        pulseClear();
        checkOutput("fir_err cleared", 64'(fir_err), 64'd0);
        clear = 1'b1;
        sendReturn(24'h0F0F0F, 2'b10);
        clear = 1'b0;
        waitDrain();
        checkOutput("set beats clear", 64'(fir_err), 64'd1);
        pulseClear();
        checkOutput("fir_err cleared again", 64'(fir_err), 64'd0);

        $display("[TB] reset between beats");
        strobeOne(0, 24'h000033);
        tick();
        applyStimulus(2'b11, {24'h000055, 24'h000044});
        m = drive_cyc;
        sink_exp.push_back('{data: 24'h000044, at: m + 2});
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("mid reset sink_valid", 64'(fir_sink_valid), 64'd0);
        checkOutput("mid reset sink_data", 64'(fir_sink_data), 64'd0);
        checkOutput("mid reset out_data", 64'(out_data), 64'd0);
        checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid reset flags", 64'({overrun, fir_err}), 64'd0);
        checkOutput("ch0 beat before reset", 64'(sink_exp.size()), 64'd0);
        sink_exp.delete();
        tick();
        reset      = 1'b0;
        out_model  = '0;
        ocnt_model = 0;
        tick();
        strobeOne(1, 24'h000077);
        for (int g = 0; g < 6; g++) tick();
        strobeOne(0, 24'h000066);
        expectFrame(drive_cyc);
        waitDrain();
        checkOutput("post reset overrun", 64'(overrun), 64'd0);
        sendReturn(24'h000099, 2'd0);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
